// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_ctrl_pkg
// Description : Shared types and constants for the stack request sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_ctrl_pkg;

    localparam int   DATA_W  = 32;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/stack_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_req_ctrl
// Description : One-at-a-time push/pop sequencer in front of a LIFO stack,
//               with occupancy tracking and overflow/underflow rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_req_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DATA  = DATA_W,
    parameter int DEPTH = 16,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [DATA-1:0] req_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DATA-1:0] rsp_data,
    output logic            rsp_err,
    output logic            stk_push,
    output logic [DATA-1:0] stk_wd,
    output logic            stk_pop,
    input  logic [DATA-1:0] stk_rd,
    input  logic            stk_v,
    input  logic            stk_busy,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);

    localparam logic [CNTW-1:0] C_DEPTH = CNTW'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_op;
    logic [DATA-1:0]   r_wd;
    rsp_t              r_rsp;
    logic [CNTW-1:0]   r_count;
    logic              w_accept;
    logic              w_reject;
    logic              w_capture;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_capture   = 1'b0;
        req_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = !stk_busy;
                if (req_valid && !stk_busy) begin
                    w_accept    = 1'b1;
                    w_reject    = (req_op == OP_PUSH) ? w_full : w_empty;
                    w_state_nxt = w_reject ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Zero-latency stacks return rd in the same cycle as the pop.
                if (r_op == OP_PUSH) begin
                    w_state_nxt = ST_RESP;
                end else if (stk_v) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stk_v) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_PUSH;
            r_wd    <= '0;
            r_rsp   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                if (req_op == OP_PUSH && !w_reject) begin
                    r_wd <= req_data;
                end
            end
            if (w_reject) begin
                r_rsp <= '{data: '0, err: 1'b1};
            end
            if (r_state == ST_ISSUE) begin
                if (r_op == OP_PUSH) begin
                    r_count <= r_count + 1'b1;
                    r_rsp   <= '0;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_capture) begin
                r_rsp <= '{data: DATA_W'(stk_rd), err: 1'b0};
            end
        end
    end

    assign stk_push  = (r_state == ST_ISSUE) && (r_op == OP_PUSH);
    assign stk_pop   = (r_state == ST_ISSUE) && (r_op == OP_POP);
    assign stk_wd    = r_wd;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = rsp_valid ? DATA'(r_rsp.data) : '0;
    assign rsp_err   = rsp_valid & r_rsp.err;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

    // Rejection in IDLE guarantees no issue ever crosses the bounds.
    a_count_max: assert property (@(posedge clk) disable iff (reset) r_count <= C_DEPTH);
    a_no_wrap: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_ISSUE) |-> ((r_op == OP_PUSH) ? !w_full : !w_empty));

endmodule
`default_nettype wire

// File: tb/tb_stack_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_req_ctrl
// Description : Self-checking bench: behavioural stack beside the DUT plus a
//               queue-based reference of the command/response contract.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_req_ctrl;

    localparam logic PUSH = 1'b0;
    localparam logic POP  = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        stk_push;
    logic [31:0] stk_wd;
    logic        stk_pop;
    logic [31:0] stk_rd;
    logic        stk_v;
    logic        stk_busy = 1'b0;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;

    // Behavioural stack environment
    logic [31:0] mem[$];
    int          lat = 0;
    int          pend = -1;
    logic [31:0] pend_word = '0;
    int          n_push = 0;
    int          n_pop = 0;
    logic [31:0] last_wd = '0;

    // Reference: contents the controller is expected to have put in the stack
    logic [31:0] ref_q[$];

    stack_req_ctrl #(.DATA(32), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_wd(stk_wd), .stk_pop(stk_pop), .stk_rd(stk_rd),
        .stk_v(stk_v), .stk_busy(stk_busy),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        stk_v  = 1'b0;
        stk_rd = '0;
        forever begin
            @(negedge clk);
            stk_v  = 1'b0;
            stk_rd = $urandom;
            if (reset) begin
                mem.delete();
                pend = -1;
            end else begin
                if (stk_push) begin
                    mem.push_back(stk_wd);
                    last_wd = stk_wd;
                    n_push++;
                end
                if (stk_pop) begin
                    n_pop++;
                    if (mem.size() > 0) pend_word = mem.pop_back();
                    else pend_word = 32'hbad0bad0;
                    pend = lat;
                end
                if (pend == 0) begin
                    stk_v  = 1'b1;
                    stk_rd = pend_word;
                    pend   = -1;
                end else if (pend > 0) begin
                    pend--;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic op, input logic [31:0] d, input int hold,
                          output logic [31:0] rd, output logic er, output bit ok);
        int t;
        ok = 1'b1;
        @(negedge clk);
        req_op = op; req_data = d; req_valid = 1'b1; rsp_ready = 1'b0;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        if (!req_ready) ok = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0; req_data = $urandom;
        @(negedge clk);
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        if (!rsp_valid) ok = 1'b0;
        rd = rsp_data; er = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            bad++; $display("FAIL reset_occ: count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0 ||
            stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_wd !== 32'd0) begin
            bad++; $display("FAIL reset_out: rv=%b re=%b rd=%h push=%b pop=%b wd=%h want all 0",
                            rsp_valid, rsp_err, rsp_data, stk_push, stk_pop, stk_wd);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ref_q.delete();
    endtask

    task automatic test_push_pop();
        logic [31:0] rd; logic er; bit ok; int p0, q0;
        lat = 0;
        p0 = n_push; q0 = n_pop;
        do_cmd(PUSH, 32'hdeadbeef, 0, rd, er, ok);
        total++;
        if (!ok || er !== 1'b0 || rd !== 32'd0) begin
            bad++; $display("FAIL push_rsp: ok=%b err=%b data=%h want 1/0/0", ok, er, rd);
        end
        total++;
        if (n_push - p0 != 1 || n_pop != q0 || last_wd !== 32'hdeadbeef || stk_wd !== 32'hdeadbeef) begin
            bad++; $display("FAIL push_pulse: pushes=%0d pops=%0d wd=%h want 1/0/deadbeef",
                            n_push - p0, n_pop - q0, last_wd);
        end
        total++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            bad++; $display("FAIL push_count: count=%0d empty=%b want 1/0", count, empty);
        end
        p0 = n_push; q0 = n_pop;
        do_cmd(POP, 32'h0, 0, rd, er, ok);
        total++;
        if (!ok || er !== 1'b0 || rd !== 32'hdeadbeef) begin
            bad++; $display("FAIL pop_rsp: ok=%b err=%b data=%h want 1/0/deadbeef", ok, er, rd);
        end
        total++;
        if (n_pop - q0 != 1 || n_push != p0 || count !== 5'd0 || empty !== 1'b1) begin
            bad++; $display("FAIL pop_state: pops=%0d pushes=%0d count=%0d empty=%b want 1/0/0/1",
                            n_pop - q0, n_push - p0, count, empty);
        end
    endtask

    task automatic test_underflow();
        logic [31:0] rd; logic er; bit ok; int q0;
        q0 = n_pop;
        do_cmd(POP, 32'h0, 1, rd, er, ok);
        total++;
        if (!ok || er !== 1'b1 || rd !== 32'd0 || n_pop != q0 || count !== 5'd0) begin
            bad++; $display("FAIL underflow: ok=%b err=%b data=%h pops=%0d count=%0d want 1/1/0/0/0",
                            ok, er, rd, n_pop - q0, count);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd; logic er; bit ok; int p0;
        for (int i = 0; i < 16; i++) begin
            lat = $urandom_range(0, 2);
            do_cmd(PUSH, 32'h100 + i, 0, rd, er, ok);
            ref_q.push_back(32'h100 + i);
        end
        total++;
        if (full !== 1'b1 || count !== 5'd16) begin
            bad++; $display("FAIL fill_full: full=%b count=%0d want 1/16", full, count);
        end
        p0 = n_push;
        do_cmd(PUSH, 32'h999, 0, rd, er, ok);
        total++;
        if (!ok || er !== 1'b1 || rd !== 32'd0 || n_push != p0 || full !== 1'b1 || count !== 5'd16) begin
            bad++; $display("FAIL overflow: ok=%b err=%b data=%h pushes=%0d full=%b count=%0d want 1/1/0/0/1/16",
                            ok, er, rd, n_push - p0, full, count);
        end
        for (int i = 15; i >= 0; i--) begin
            lat = $urandom_range(0, 3);
            do_cmd(POP, 32'h0, $urandom_range(0, 1), rd, er, ok);
            void'(ref_q.pop_back());
            total++;
            if (!ok || er !== 1'b0 || rd !== 32'h100 + i || count !== 5'(i)) begin
                bad++; $display("FAIL lifo_pop: ok=%b err=%b data=%h count=%0d want 1/0/%h/%0d",
                                ok, er, rd, count, 32'h100 + i, i);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd; logic er; bit ok; int t;
        lat = 0;
        do_cmd(PUSH, 32'h55, 0, rd, er, ok);
        lat = 2;
        @(negedge clk);
        req_op = POP; req_valid = 1'b1; rsp_ready = 1'b0;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 req_op = PUSH; req_data = 32'h77;
        @(negedge clk);
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable: cyc=%0d rv=%b data=%h err=%b rdy=%b want 1/55/0/0",
                                k, rsp_valid, rsp_data, rsp_err, req_ready);
            end
            if (k < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || stk_push !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL hold_after: rdy=%b push=%b rv=%b want 1/0/0", req_ready, stk_push, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (stk_push !== 1'b1 || stk_wd !== 32'h77) begin
            bad++; $display("FAIL hold_next: push=%b wd=%h want 1/77", stk_push, stk_wd);
        end
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        ref_q.push_back(32'h77);
    endtask

    task automatic test_busy();
        int p0, q0;
        p0 = n_push; q0 = n_pop;
        @(negedge clk);
        stk_busy = 1'b1; req_valid = 1'b1; req_op = PUSH; req_data = 32'habc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 1'b0 || stk_push !== 1'b0 || stk_pop !== 1'b0 || rsp_valid !== 1'b0) begin
                bad++; $display("FAIL busy_block: rdy=%b push=%b pop=%b rv=%b want 0/0/0/0",
                                req_ready, stk_push, stk_pop, rsp_valid);
            end
        end
        req_valid = 1'b0; stk_busy = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (n_push != p0 || n_pop != q0 || count !== 5'(ref_q.size())) begin
            bad++; $display("FAIL busy_none: pushes=%0d pops=%0d count=%0d want 0/0/%0d",
                            n_push - p0, n_pop - q0, count, ref_q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_d; logic er, exp_e, op; bit ok; int p0, q0, exp_np, exp_nq;
        for (int i = 0; i < 80; i++) begin
            op  = ($urandom_range(0, 99) < 55) ? PUSH : POP;
            d   = $urandom;
            lat = $urandom_range(0, 3);
            exp_np = 0; exp_nq = 0; exp_d = 32'd0;
            if (op == PUSH) begin
                exp_e = (ref_q.size() == 16);
                if (!exp_e) begin ref_q.push_back(d); exp_np = 1; end
            end else begin
                exp_e = (ref_q.size() == 0);
                if (!exp_e) begin exp_d = ref_q.pop_back(); exp_nq = 1; end
            end
            p0 = n_push; q0 = n_pop;
            do_cmd(op, d, $urandom_range(0, 2), rd, er, ok);
            total++;
            if (!ok || rd !== exp_d || er !== exp_e) begin
                bad++; $display("FAIL rand_rsp[%0d]: op=%b ok=%b data=%h err=%b want data=%h err=%b",
                                i, op, ok, rd, er, exp_d, exp_e);
            end
            total++;
            if (count !== 5'(ref_q.size()) || full !== (ref_q.size() == 16) || empty !== (ref_q.size() == 0)) begin
                bad++; $display("FAIL rand_occ[%0d]: count=%0d full=%b empty=%b want count=%0d",
                                i, count, full, empty, ref_q.size());
            end
            total++;
            if (n_push - p0 != exp_np || n_pop - q0 != exp_nq || (exp_np == 1 && last_wd !== d)) begin
                bad++; $display("FAIL rand_pulse[%0d]: pushes=%0d pops=%0d wd=%h want %0d/%0d/%h",
                                i, n_push - p0, n_pop - q0, last_wd, exp_np, exp_nq, d);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; bit ok; int t, p0, q0;
        lat = 0;
        do_cmd(PUSH, 32'h31, 0, rd, er, ok);
        lat = 5;
        @(negedge clk);
        req_op = POP; req_valid = 1'b1; rsp_ready = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (stk_pop !== 1'b1) begin
            bad++; $display("FAIL rw_issue: pop=%b want 1", stk_pop);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rw_reset: rv=%b count=%0d empty=%b rdy=%b want 0/0/1/1",
                            rsp_valid, count, empty, req_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0; rsp_ready = 1'b0;
        ref_q.delete();
        p0 = n_push; q0 = n_pop;
        repeat (8) @(negedge clk);
        total++;
        if (n_push != p0 || n_pop != q0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rw_quiet: pushes=%0d pops=%0d rv=%b want 0/0/0",
                            n_push - p0, n_pop - q0, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_fill();
        test_hold();
        test_busy();
        test_random();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
